mac_dot_product_sequencer: RTL and testbench

MAC_DOT_PRODUCT_SEQUENCER -- requirements
Module: mac_dot_product_sequencer

---
 rtl/mac_dot_product_sequencer.sv | 123 ++++++++++++
 tb/tb_mac_dot_product_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_product_sequencer.sv
// rtl/mac_dot_product_sequencer.sv - sequences operand beats through an external four-lane MAC and accumulates a dot product
module mac_dot_product_sequencer #(
    parameter int MAC_LATENCY = 2,
    parameter int ACC_WIDTH   = 32,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clock0,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_num_beats,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_dataa,
    input  logic [31:0]          in_datab,
    output logic [31:0]          mac_dataa,
    output logic [31:0]          mac_datab,
    input  logic [15:0]          mac_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Tag pattern meaning "only the final beat is still in flight, at the last stage".
    localparam logic [MAC_LATENCY-1:0] TAG_LAST = MAC_LATENCY'(1) << (MAC_LATENCY - 1);

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   num_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [MAC_LATENCY-1:0] tag_q;
    logic [MAC_LATENCY-1:0] tag_d;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [ACC_WIDTH-1:0]   acc_d;
    logic [ACC_WIDTH-1:0]   out_data_q;

    logic                   accept;
    logic                   last_beat;
    logic                   drain_done;
    logic signed [15:0]     mac_s;
    logic [ACC_WIDTH-1:0]   mac_ext;

    // Ready depends only on state; cfg_ready is also held low while reset is applied.
    assign cfg_ready = (state_q == IDLE) && !reset;
    assign in_ready  = (state_q == RUN);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && ((cnt_q + CNT_WIDTH'(1)) == num_q);

    // Operands only reach the MAC in the accept cycle so idle cycles present zeros.
    assign mac_dataa = accept ? in_dataa : 32'd0;
    assign mac_datab = accept ? in_datab : 32'd0;

    assign mac_s   = mac_result;
    assign mac_ext = ACC_WIDTH'(mac_s);

    // The tag pipeline tracks which MAC outputs correspond to accepted beats.
    assign tag_d      = (tag_q << 1) | MAC_LATENCY'(accept);
    assign acc_d      = acc_q + (tag_q[MAC_LATENCY-1] ? mac_ext : '0);
    assign drain_done = (tag_q == TAG_LAST);

    // Control FSM together with the beat counter, accumulator and result register.
    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            num_q      <= '0;
            cnt_q      <= '0;
            tag_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            tag_q <= tag_d;
            acc_q <= acc_d;
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        num_q <= cfg_num_beats;
                        cnt_q <= '0;
                        acc_q <= '0;
                        tag_q <= '0;
                        if (cfg_num_beats == '0) begin
                            out_data_q <= '0;
                            state_q    <= OUT;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (last_beat) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        out_data_q <= acc_d;
                        state_q    <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_product_sequencer.sv
// tb/tb_mac_dot_product_sequencer.sv - self-checking bench for mac_dot_product_sequencer
`timescale 1ns/1ps
module tb_mac_dot_product_sequencer;

    localparam int L = 2;

    logic        clock0 = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic [7:0]  cfg_num_beats;
    logic        in_valid;
    logic [31:0] in_dataa;
    logic [31:0] in_datab;
    logic [15:0] mac_result;
    logic        out_ready;

    logic        cfg_ready,  in_ready,  out_valid,  busy;
    logic [31:0] mac_dataa,  mac_datab, out_data;
    logic        cfg_ready16, in_ready16, out_valid16, busy16;
    logic [31:0] mac_dataa16, mac_datab16;
    logic [15:0] out_data16;

    always #5 clock0 = ~clock0;

    mac_dot_product_sequencer #(.MAC_LATENCY(L), .ACC_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clock0(clock0), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_num_beats(cfg_num_beats),
        .in_valid(in_valid), .in_ready(in_ready), .in_dataa(in_dataa), .in_datab(in_datab),
        .mac_dataa(mac_dataa), .mac_datab(mac_datab), .mac_result(mac_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    // Narrow-accumulator twin sees identical stimulus to exercise wraparound.
    mac_dot_product_sequencer #(.MAC_LATENCY(L), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut16 (
        .clock0(clock0), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready16), .cfg_num_beats(cfg_num_beats),
        .in_valid(in_valid), .in_ready(in_ready16), .in_dataa(in_dataa), .in_datab(in_datab),
        .mac_dataa(mac_dataa16), .mac_datab(mac_datab16), .mac_result(mac_result),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .busy(busy16)
    );

    // External MAC model: four signed 8x8 products summed into a wrapping 16-bit result.
    function automatic logic [15:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic signed [7:0]  x, y;
        logic signed [15:0] p, s;
        s = 16'sd0;
        for (int k = 0; k < 4; k++) begin
            x = a[8*k +: 8];
            y = b[8*k +: 8];
            p = x * y;
            s = s + p;
        end
        return s;
    endfunction

    logic [15:0] pipe [L];
    always @(posedge clock0 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < L; i++) pipe[i] <= 16'd0;
        end else begin
            pipe[0] <= dot4(mac_dataa, mac_datab);
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mac_result = pipe[L-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] sb_q [$];

    // Scoreboard: compare the held result every OUT cycle, pop on handshake.
    always @(negedge clock0) begin
        if (!reset && out_valid) begin
            if (sb_q.size() == 0) begin
                if (out_ready) check("unexpected_out", 128'(out_valid), 128'(0));
            end else begin
                check("out_data", 128'(out_data), 128'(sb_q[0]));
                check("out_data16", 128'(out_data16), 128'(sb_q[0][15:0]));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    typedef struct {
        int              nb;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        int              gap;
        int              hold;
        logic [31:0]     exp;
    } vec_t;

    vec_t vt [7];

    task automatic setv(input int i, input int nb, input int gap, input int hold, input logic [31:0] exp);
        vt[i].nb   = nb;
        vt[i].gap  = gap;
        vt[i].hold = hold;
        vt[i].exp  = exp;
        vt[i].a    = '0;
        vt[i].b    = '0;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_dataa = a;
        in_datab = b;
        @(negedge clock0);
        for (int w = 0; w < 20 && !in_ready; w++) begin
            @(posedge clock0); #1;
            @(negedge clock0);
        end
        check("beat_in_ready", 128'(in_ready), 128'(1));
        check("mac_operands", {mac_dataa, mac_datab, mac_dataa16, mac_datab16}, {a, b, a, b});
        @(posedge clock0); #1;
        in_valid = 1'b0;
        in_dataa = 32'd0;
        in_datab = 32'd0;
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int exp_lat;
        logic seen;
        out_ready     = (v.hold == 0);
        cfg_valid     = 1'b1;
        cfg_num_beats = 8'(v.nb);
        @(negedge clock0);
        check("cfg_ready_idle", {cfg_ready, busy, cfg_ready16}, 3'b101);
        sb_q.push_back(v.exp);
        @(posedge clock0); #1;
        cfg_valid = 1'b0;

        for (int i = 0; i < v.nb; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    cfg_valid     = 1'b1;
                    cfg_num_beats = 8'd0;
                    @(negedge clock0);
                    check("bubble_run", {in_ready, in_ready16, mac_dataa, mac_datab}, {2'b11, 64'd0});
                    @(posedge clock0); #1;
                    cfg_valid = 1'b0;
                end
            end
            send_beat(v.a[i], v.b[i]);
        end

        // Junk beats offered outside RUN must never reach the MAC.
        in_valid = 1'b1;
        in_dataa = 32'h7F7F7F7F;
        in_datab = 32'h7F7F7F7F;
        exp_lat  = (v.nb == 0) ? 1 : L + 1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clock0);
            k++;
            check("ignored_beat", {in_ready, in_ready16, mac_dataa, mac_datab}, 128'd0);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clock0); #1;
            end
        end
        check("out_latency", 128'(k), 128'(exp_lat));
        check("out_valid16", 128'(out_valid16), 128'(1));

        if (v.hold > 0) begin
            for (int h = 1; h < v.hold; h++) begin
                @(posedge clock0); #1;
                @(negedge clock0);
                check("out_hold", {out_valid, out_valid16, busy}, 3'b111);
            end
            @(posedge clock0); #1;
            out_ready = 1'b1;
            @(negedge clock0);
        end
        @(posedge clock0); #1;
        in_valid = 1'b0;
        in_dataa = 32'd0;
        in_datab = 32'd0;
        @(negedge clock0);
        check("back_to_idle", {busy, cfg_ready, out_valid, in_ready, busy16, out_valid16}, 6'b010000);
        @(posedge clock0); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        cfg_valid     = 1'b0;
        cfg_num_beats = 8'd0;
        in_valid      = 1'b0;
        in_dataa      = 32'd0;
        in_datab      = 32'd0;
        out_ready     = 1'b1;

        setv(0, 1, 0, 0, 32'h00000008);
        vt[0].a[0] = 32'h01010101; vt[0].b[0] = 32'h02020202;
        setv(1, 3, 2, 5, 32'h00000102);
        vt[1].a[0] = 32'h01020304; vt[1].b[0] = 32'h05060708;
        vt[1].a[1] = 32'h10101010; vt[1].b[1] = 32'h03030303;
        vt[1].a[2] = 32'hFFFFFFFF; vt[1].b[2] = 32'h01010101;
        // Four lanes of -128*127 exceed the 16-bit MAC port and wrap to +512 per beat.
        setv(2, 2, 0, 0, 32'h00000400);
        vt[2].a[0] = 32'h80808080; vt[2].b[0] = 32'h7F7F7F7F;
        vt[2].a[1] = 32'h80808080; vt[2].b[1] = 32'h7F7F7F7F;
        setv(3, 2, 1, 1, 32'hFFFFC080);
        vt[3].a[0] = 32'hF0F0F0F0; vt[3].b[0] = 32'h7F7F7F7F;
        vt[3].a[1] = 32'hF0F0F0F0; vt[3].b[1] = 32'h7F7F7F7F;
        setv(4, 2, 0, 2, 32'hFFFFF808);
        vt[4].a[0] = 32'h7F7F7F7F; vt[4].b[0] = 32'h7F7F7F7F;
        vt[4].a[1] = 32'h7F7F7F7F; vt[4].b[1] = 32'h7F7F7F7F;
        setv(5, 0, 0, 3, 32'h00000000);
        setv(6, 4, 1, 0, 32'h00000100);
        vt[6].a[0] = 32'h00000001; vt[6].b[0] = 32'h00000005;
        vt[6].a[1] = 32'h00000100; vt[6].b[1] = 32'h00000300;
        vt[6].a[2] = 32'h02000000; vt[6].b[2] = 32'h7F000000;
        vt[6].a[3] = 32'h000000FE; vt[6].b[3] = 32'h00000003;

        repeat (3) @(negedge clock0);
        check("reset_ctrl", {cfg_ready, in_ready, out_valid, busy, cfg_ready16, busy16}, 6'd0);
        check("reset_data", {out_data, out_data16, mac_dataa, mac_datab}, 128'd0);
        @(posedge clock0); #1;
        reset = 1'b0;
        @(negedge clock0);
        check("cfg_ready_after_reset", {cfg_ready, busy}, 2'b10);
        @(posedge clock0); #1;

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Reset while draining: in-flight result is dropped and outputs clear.
        cfg_valid     = 1'b1;
        cfg_num_beats = 8'd2;
        @(posedge clock0); #1;
        cfg_valid = 1'b0;
        send_beat(32'h7F7F7F7F, 32'h7F7F7F7F);
        send_beat(32'h7F7F7F7F, 32'h7F7F7F7F);
        @(negedge clock0);
        check("drain_state", {busy, in_ready, out_valid}, 3'b100);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_dataa = 32'h12345678;
        in_datab = 32'h01010101;
        #1;
        check("midreset_ctrl", {cfg_ready, in_ready, out_valid, busy, busy16}, 5'd0);
        check("midreset_data", {out_data, out_data16, mac_dataa, mac_datab}, 128'd0);
        repeat (2) @(negedge clock0);
        check("midreset_hold", {cfg_ready, in_ready, out_valid, busy, out_data}, 36'd0);
        @(posedge clock0); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_dataa = 32'd0;
        in_datab = 32'd0;
        @(negedge clock0);
        check("cfg_ready_after_midreset", {cfg_ready, busy}, 2'b10);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock0);
            check("no_out_after_reset", {out_valid, out_valid16, busy}, 3'b000);
        end
        @(posedge clock0); #1;

        run_vec(vt[4]);
        run_vec(vt[0]);

        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
